// File: rtl/id_ex_hazard_ctrl.sv
// ID/EX hazard and sequencing controller for the RV32IF pipeline.
// Handles load-use stalls, EX-stage redirects and the multi-cycle integer
// divider freeze, and keeps a saturating count of PC stall cycles.
module id_ex_hazard_ctrl #(
  parameter int DIV_LAT = 16,
  parameter int CNT_W   = 5,
  parameter int PERF_W  = 16
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic [4:0]        if_id_rs1,
  input  logic [4:0]        if_id_rs2,
  input  logic              rs1_used,
  input  logic              rs2_used,
  input  logic [4:0]        id_ex_rd,
  input  logic              id_ex_mem_rd,
  input  logic              id_ex_idiv,
  input  logic              ex_redirect,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              if_id_flush,
  output logic              id_ex_hold,
  output logic              id_ex_bubble,
  output logic              ex_mem_bubble,
  output logic              div_start,
  output logic              div_done,
  output logic              div_busy,
  output logic [PERF_W-1:0] stall_cycles
);

  typedef enum logic {
    RUN = 1'b0,
    DIV = 1'b1
  } state_t;

  // The detect cycle is the first of DIV_LAT and the release cycle the last,
  // so the countdown loaded on detect covers the DIV_LAT-2 cycles in between.
  localparam logic [CNT_W-1:0]  COUNT_INIT = CNT_W'(DIV_LAT - 2);
  localparam logic [PERF_W-1:0] STALL_MAX  = '1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PERF_W-1:0] stall_q, stall_d;
  logic              lu;

  // Load in EX writes a register the ID instruction reads; x0 never hazards.
  assign lu = id_ex_mem_rd && (id_ex_rd != 5'd0) &&
              ((rs1_used && (if_id_rs1 == id_ex_rd)) ||
               (rs2_used && (if_id_rs2 == id_ex_rd)));

  // Pipeline controls and next state: divider freeze beats redirect beats load-use.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_hold    = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    div_start     = 1'b0;
    div_done      = 1'b0;
    div_busy      = 1'b0;
    if (!rst) begin
      case (state_q)
        RUN: begin
          if (id_ex_idiv) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_hold    = 1'b1;
            ex_mem_bubble = 1'b1;
            div_start     = 1'b1;
            count_d       = COUNT_INIT;
            state_d       = DIV;
          end else if (ex_redirect) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (lu) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
          end
        end
        DIV: begin
          div_busy = 1'b1;
          if (count_q != '0) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_hold    = 1'b1;
            ex_mem_bubble = 1'b1;
            count_d       = count_q - 1'b1;
          end else begin
            div_done = 1'b1;
            state_d  = RUN;
          end
        end
        default: begin
          state_d = RUN;
          count_d = '0;
        end
      endcase
    end
  end

  // Stall-cycle counter sticks at its maximum instead of wrapping.
  always_comb begin
    stall_d = stall_q;
    if (pc_stall && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  // State, countdown and performance counter registers.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      count_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;

endmodule
